// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, control codes and request/response structs
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int CTR_W   = 3;
  localparam int SHAMT_W = 5;

  localparam logic [CTR_W-1:0] ALU_AND = 3'b000;
  localparam logic [CTR_W-1:0] ALU_OR  = 3'b001;
  localparam logic [CTR_W-1:0] ALU_ADD = 3'b010;
  localparam logic [CTR_W-1:0] ALU_XOR = 3'b011;
  localparam logic [CTR_W-1:0] ALU_SLT = 3'b100;
  localparam logic [CTR_W-1:0] ALU_SLL = 3'b101;
  localparam logic [CTR_W-1:0] ALU_SUB = 3'b110;
  localparam logic [CTR_W-1:0] ALU_NOR = 3'b111;

  typedef struct packed {
    logic [CTR_W-1:0]   ctr;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [SHAMT_W-1:0] shamt;
  } alu_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              ovf;
  } alu_rsp_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - two-port request/response bus between EX logic and the ALU arbiter
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int CTR_W   = alu_pkg::CTR_W,
  parameter int SHAMT_W = alu_pkg::SHAMT_W
);

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*CTR_W-1:0]   req_ctr;
  logic [2*DATA_W-1:0]  req_a;
  logic [2*DATA_W-1:0]  req_b;
  logic [2*SHAMT_W-1:0] req_shamt;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [2*DATA_W-1:0]  rsp_res;
  logic [1:0]           rsp_zero;
  logic [1:0]           rsp_ovf;

  modport master (
    output req_valid, req_ctr, req_a, req_b, req_shamt, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_ovf
  );

  modport slave (
    input  req_valid, req_ctr, req_a, req_b, req_shamt, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_ovf
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rtl/alu_share_arbiter_rr_arb2.sv - two-way round-robin grant; port 0 wins the first contest
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters with a one-entry response buffer per port
// Optional per-port stall counters are built when ALU_ARB_STALL_CNT_EN is defined.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int CTR_W   = alu_pkg::CTR_W,
  parameter int SHAMT_W = alu_pkg::SHAMT_W,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   bus,
  output logic [CTR_W-1:0]     alu_ctr,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [SHAMT_W-1:0]   alu_shamt,
  input  logic [DATA_W-1:0]    alu_res,
  input  logic                 alu_zero,
  input  logic                 alu_overflow
`ifdef ALU_ARB_STALL_CNT_EN
  ,
  output logic [2*CNT_W-1:0]   stall_cnt
`endif
);

  logic                 issue_vld;
  logic                 issue_port;
  logic [1:0]           in_flight;
  logic [1:0]           drain;
  logic [1:0]           elig;
  logic [1:0]           grant;
  logic [1:0]           rsp_vld;
  logic [2*DATA_W-1:0]  rsp_res_q;
  logic [1:0]           rsp_zero_q;
  logic [1:0]           rsp_ovf_q;
  logic [CTR_W-1:0]     sel_ctr;
  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;
  logic [SHAMT_W-1:0]   sel_shamt;

  // A port with an op in the ALU must wait for its capture, so its buffer is never overwritten.
  always_comb begin
    in_flight = 2'b00;
    if (issue_vld) begin
      in_flight = issue_port ? 2'b10 : 2'b01;
    end
    drain = rsp_vld & bus.rsp_ready;
    elig  = bus.req_valid & (~rsp_vld | drain) & ~in_flight;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .elig  (elig),
    .grant (grant)
  );

  assign bus.req_ready = grant;

  always_comb begin
    if (grant[1]) begin
      sel_ctr   = bus.req_ctr[2*CTR_W-1:CTR_W];
      sel_a     = bus.req_a[2*DATA_W-1:DATA_W];
      sel_b     = bus.req_b[2*DATA_W-1:DATA_W];
      sel_shamt = bus.req_shamt[2*SHAMT_W-1:SHAMT_W];
    end else begin
      sel_ctr   = bus.req_ctr[CTR_W-1:0];
      sel_a     = bus.req_a[DATA_W-1:0];
      sel_b     = bus.req_b[DATA_W-1:0];
      sel_shamt = bus.req_shamt[SHAMT_W-1:0];
    end
  end

  // The issue register doubles as the ALU operand driver; it only loads on a grant so idle ALU inputs hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_vld  <= 1'b0;
      issue_port <= 1'b0;
      alu_ctr    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_shamt  <= '0;
    end else begin
      issue_vld <= |grant;
      if (|grant) begin
        issue_port <= grant[1];
        alu_ctr    <= sel_ctr;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        alu_shamt  <= sel_shamt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld    <= 2'b00;
      rsp_res_q  <= '0;
      rsp_zero_q <= 2'b00;
      rsp_ovf_q  <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (in_flight[p]) begin
          rsp_vld[p]                     <= 1'b1;
          rsp_res_q[p*DATA_W +: DATA_W]  <= alu_res;
          rsp_zero_q[p]                  <= alu_zero;
          rsp_ovf_q[p]                   <= alu_overflow;
        end else if (drain[p]) begin
          rsp_vld[p] <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_ovf   = rsp_ovf_q;

`ifdef ALU_ARB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q[0] <= '0;
      stall_q[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid[p] && !grant[p] && (stall_q[p] != {CNT_W{1'b1}})) begin
          stall_q[p] <= stall_q[p] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign stall_cnt = {stall_q[1], stall_q[0]};
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  alu_shamt;
  logic        alu_zero, alu_overflow;
  alu_rsp_t    alu_out;
`ifdef ALU_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .alu_ctr      (alu_ctr),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_shamt    (alu_shamt),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow)
`ifdef ALU_ARB_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic alu_rsp_t alu_model(input logic [2:0] ctr, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    alu_rsp_t r;
    r = '0;
    case (ctr)
      ALU_AND: r.res = a & b;
      ALU_OR:  r.res = a | b;
      ALU_ADD: begin
        r.res = a + b;
        r.ovf = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      ALU_XOR: r.res = a ^ b;
      ALU_SLT: r.res = {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: r.res = b << sh;
      ALU_SUB: begin
        r.res = a - b;
        r.ovf = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      default: r.res = ~(a | b);
    endcase
    r.zero = (r.res == 32'h0);
    return r;
  endfunction

  always_comb alu_out = alu_model(alu_ctr, alu_a, alu_b, alu_shamt);
  assign alu_res      = alu_out.res;
  assign alu_zero     = alu_out.zero;
  assign alu_overflow = alu_out.ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] hs;
  alu_rsp_t exp_q0[$];
  alu_rsp_t exp_q1[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic set_req(input int p, input logic [2:0] ctr, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    bus.req_ctr[p*3 +: 3]    = ctr;
    bus.req_a[p*32 +: 32]    = a;
    bus.req_b[p*32 +: 32]    = b;
    bus.req_shamt[p*5 +: 5]  = sh;
  endtask

  task automatic rnd_req(input int p);
    set_req(p, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
  endtask

  // One clock: observe handshakes at the falling edge, then move past the rising edge.
  task automatic step();
    alu_rsp_t e;
    alu_rsp_t got;
    @(negedge clk);
    hs = reset ? 2'b00 : (bus.req_valid & bus.req_ready);
    for (int p = 0; p < 2; p++) begin
      if (hs[p]) begin
        e = alu_model(bus.req_ctr[p*3 +: 3], bus.req_a[p*32 +: 32],
                      bus.req_b[p*32 +: 32], bus.req_shamt[p*5 +: 5]);
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (!reset && bus.rsp_valid[p] && bus.rsp_ready[p]) begin
        got.res  = bus.rsp_res[p*32 +: 32];
        got.zero = bus.rsp_zero[p];
        got.ovf  = bus.rsp_ovf[p];
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
          chk($sformatf("rsp%0d_unexpected", p), 64'd1, 64'd0);
        end else begin
          e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("rsp%0d_data", p), 64'(got), 64'(e));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_ctr   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_shamt = '0;
    repeat (3) step();
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_res", 64'(bus.rsp_res[31:0]), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_ctr", 64'(alu_ctr), 64'd0);
    reset = 1'b0;
    step();

    // Single port-0 op: ready same cycle, ALU operand next cycle, response two cycles later.
    bus.rsp_ready = 2'b11;
    set_req(0, 3'b111, 32'ha5a5a5a5, 32'h5a5a5a5a, 5'd0);
    bus.req_valid = 2'b01;
    #1;
    chk("t1_req_ready", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 2'b00;
    chk("t1_alu_a", 64'(alu_a), 64'ha5a5a5a5);
    chk("t1_rsp_not_yet", 64'(bus.rsp_valid), 64'd0);
    step();
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t1_rsp_res", 64'(bus.rsp_res[31:0]), 64'h0);
    chk("t1_rsp_zero", 64'(bus.rsp_zero[0]), 64'h1);
    step();
    chk("t1_rsp_drained", 64'(bus.rsp_valid), 64'd0);

    // Both ports continuously valid: port 1 wins first, then strict alternation.
    rnd_req(0);
    rnd_req(1);
    bus.req_valid = 2'b11;
    exp_g = 2'b10;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t2_alt_grant", 64'(hs), 64'(exp_g));
      exp_g = ~exp_g;
      for (int p = 0; p < 2; p++) if (hs[p]) rnd_req(p);
    end
    bus.req_valid = 2'b00;
    repeat (3) step();
    chk("t2_q_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    // Port 1 consumer stalled: one issue, then blocked while port 0 keeps going.
    bus.rsp_ready = 2'b01;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_g = (i == 0) ? 2'b10 : ((i % 2 == 1) ? 2'b01 : 2'b00);
      chk("t3_grant", 64'(hs), 64'(exp_g));
      for (int p = 0; p < 2; p++) if (hs[p]) rnd_req(p);
    end
    chk("t3_rsp1_held", 64'(bus.rsp_valid[1]), 64'h1);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b11;
    #1;
    chk("t3_drain_frees", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = 2'b00;
    repeat (3) step();
    chk("t3_q_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    // Repeated shift on port 0: one issue every second cycle.
    set_req(0, 3'b101, 32'h01234567, 32'h76543210, 5'd8);
    bus.req_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_issue", 64'(hs), (i % 2 == 0) ? 64'h1 : 64'h0);
      if (bus.rsp_valid[0]) chk("t4_res", 64'(bus.rsp_res[31:0]), 64'h54321000);
    end
    bus.req_valid = 2'b00;
    repeat (3) step();
    chk("t4_q_empty", 64'(exp_q0.size()), 64'd0);

    // Reset right after a grant discards the in-flight op.
    set_req(0, 3'b010, 32'h11111111, 32'h22222222, 5'd3);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q0.delete();
    chk("t5_alu_a", 64'(alu_a), 64'd0);
    chk("t5_alu_ctr", 64'(alu_ctr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end

`ifdef ALU_ARB_STALL_CNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.rsp_ready = 2'b01;
    rnd_req(1);
    bus.req_valid = 2'b10;
    step();
    repeat (10) step();
    chk("stall_cnt_10", 64'(stall_cnt[31:16]), 64'd10);
    repeat (65540) step();
    chk("stall_cnt_sat", 64'(stall_cnt[31:16]), 64'hffff);
    bus.req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
`endif

    chk("final_q_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
